// File: rtl/ocp_pkg.sv
// Shared OCP encodings for the single-threaded slave memory model.
package ocp_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE = 3'd0,
    CMD_WR   = 3'd1,
    CMD_RD   = 3'd2
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'd0,
    RESP_DVA  = 2'd1,
    RESP_ERR  = 2'd3
  } ocp_resp_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } slv_state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/ocp_slv_ram.sv
// Word-addressed RAM with byte-enabled write and registered read port.
// Contents are never reset; the read register only updates on re_i.
module ocp_slv_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                re_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/ocp_slave_mem.sv
// OCP 2.x single-threaded slave with internal RAM and programmable read latency.
// Define OCP_SLV_WR_RESP_EN to make writes non-posted (DVA/ERR response per write).
module ocp_slave_mem
  import ocp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          MCmd,
  input  logic [ADDR_W-1:0]   MAddr,
  input  logic [DATA_W-1:0]   MData,
  input  logic [DATA_W/8-1:0] MByteEn,
  output logic                SCmdAccept,
  output logic [1:0]          SResp,
  output logic [DATA_W-1:0]   SData,
  input  logic                MRespAccept
);

  localparam int OFF = $clog2(DATA_W/8);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  slv_state_e        state_q;
  logic              acc_q;
  ocp_resp_e         resp_q;
  logic              dval_q;
  logic              pend_err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] widx;
  logic              in_range;
  logic              cmd_acc;
  logic              is_wr;
  logic              is_rd;
  logic [DATA_W-1:0] ram_rdata;

  assign widx     = MAddr >> OFF;
  assign in_range = widx < ADDR_W'(DEPTH);
  assign cmd_acc  = acc_q && (MCmd != CMD_IDLE);
  assign is_wr    = MCmd == CMD_WR;
  assign is_rd    = MCmd == CMD_RD;

  ocp_slv_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (cmd_acc && is_wr && in_range),
    .be_i    (MByteEn),
    .addr_i  (widx[AW-1:0]),
    .wdata_i (MData),
    .re_i    (cmd_acc && is_rd && in_range),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      acc_q      <= 1'b0;
      resp_q     <= RESP_NULL;
      dval_q     <= 1'b0;
      pend_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          state_q <= ST_IDLE;
          acc_q   <= 1'b1;
        end
        ST_IDLE: begin
          if (cmd_acc) begin
            if (is_wr) begin
`ifdef OCP_SLV_WR_RESP_EN
              state_q <= ST_RESP;
              acc_q   <= 1'b0;
              resp_q  <= in_range ? RESP_DVA : RESP_ERR;
              dval_q  <= 1'b0;
`else
              state_q <= ST_IDLE;
`endif
            end else if (is_rd) begin
              acc_q <= 1'b0;
              if (RD_LAT == 1) begin
                state_q <= ST_RESP;
                resp_q  <= in_range ? RESP_DVA : RESP_ERR;
                dval_q  <= in_range;
              end else begin
                state_q    <= ST_WAIT;
                cnt_q      <= CNT_W'(RD_LAT - 1);
                pend_err_q <= !in_range;
              end
            end else begin
              // Illegal opcodes are still accepted so the master never stalls on them.
              state_q <= ST_RESP;
              acc_q   <= 1'b0;
              resp_q  <= RESP_ERR;
              dval_q  <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_RESP;
            cnt_q   <= '0;
            resp_q  <= pend_err_q ? RESP_ERR : RESP_DVA;
            dval_q  <= !pend_err_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (MRespAccept) begin
            state_q <= ST_IDLE;
            acc_q   <= 1'b1;
            resp_q  <= RESP_NULL;
            dval_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          acc_q   <= 1'b0;
          resp_q  <= RESP_NULL;
          dval_q  <= 1'b0;
        end
      endcase
    end
  end

  // The RAM read register holds its value until the next accepted read, so it can drive SData directly.
  assign SCmdAccept = acc_q;
  assign SResp      = resp_q;
  assign SData      = dval_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Directed + randomized bench for ocp_slave_mem against a word-array reference model.
module tb_ocp_slave_mem;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        MCmd = 3'd0;
  logic [ADDR_W-1:0] MAddr = '0;
  logic [DATA_W-1:0] MData = '0;
  logic [3:0]        MByteEn = '0;
  logic              SCmdAccept;
  logic [1:0]        SResp;
  logic [DATA_W-1:0] SData;
  logic              MRespAccept = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [31:0] mem [DEPTH];

  ocp_slave_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MCmd        (MCmd),
    .MAddr       (MAddr),
    .MData       (MData),
    .MByteEn     (MByteEn),
    .SCmdAccept  (SCmdAccept),
    .SResp       (SResp),
    .SData       (SData),
    .MRespAccept (MRespAccept)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_acc();
    int i = 0;
    while (SCmdAccept !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("acc_timeout", SCmdAccept, 1);
  endtask

  // Issue one command; expect a response lat edges after the accept edge's cycle, held hold cycles.
  task automatic do_cmd(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int lat, input logic [1:0] er,
                        input logic [31:0] ed, input int hold);
    wait_acc();
    MCmd = cmd; MAddr = addr; MData = data; MByteEn = be;
    @(negedge clk);
    MCmd = 3'd0;
    for (int k = 1; k < lat; k++) begin
      chk("wait_resp", SResp, 0);
      chk("wait_acc", SCmdAccept, 0);
      @(negedge clk);
    end
    chk("resp", SResp, er);
    chk("data", SData, ed);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_resp", SResp, er);
      chk("hold_data", SData, ed);
      chk("hold_acc", SCmdAccept, 0);
    end
    MRespAccept = 1'b1;
    @(negedge clk);
    MRespAccept = 1'b0;
    chk("retire_resp", SResp, 0);
    chk("retire_data", SData, 0);
    chk("retire_acc", SCmdAccept, 1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    int idx;
    idx = int'(addr >> 2);
`ifdef OCP_SLV_WR_RESP_EN
    do_cmd(3'd1, addr, data, be, 1, (addr >> 2) < DEPTH ? 2'd1 : 2'd3, 32'h0, 0);
`else
    wait_acc();
    MCmd = 3'd1; MAddr = addr; MData = data; MByteEn = be;
    @(negedge clk);
    MCmd = 3'd0;
    chk("post_resp", SResp, 0);
    chk("post_acc", SCmdAccept, 1);
`endif
    if ((addr >> 2) < DEPTH) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    if ((addr >> 2) < DEPTH) do_cmd(3'd2, addr, 32'h0, 4'h0, RD_LAT, 2'd1, mem[int'(addr >> 2)], hold);
    else do_cmd(3'd2, addr, 32'h0, 4'h0, RD_LAT, 2'd3, 32'h0, hold);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_acc", SCmdAccept, 0);
    chk("rst_resp", SResp, 0);
    chk("rst_data", SData, 0);
    rst_n = 1'b1;
    #1;
    chk("init_acc", SCmdAccept, 0);
    @(negedge clk);
    chk("idle_acc", SCmdAccept, 1);
    chk("idle_resp", SResp, 0);

    // Initialise the words the random phase touches.
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF);

    // Directed: full write, read back, partial overwrite, back-to-back write-then-read.
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10, 0);
    chk("dir_full", mem[4], 32'hDEADBEEF);
    do_write(32'h10, 32'h000000AA, 4'h1);
    chk("dir_part", mem[4], 32'hDEADBEAA);
    do_read(32'h13, 5);

    // Out-of-range write must not alias onto word 4.
    do_write(32'(DEPTH * 4 + 16), 32'h12345678, 4'hF);
    do_read(32'h10, 0);
    do_read(32'(DEPTH * 4), 1);
    do_cmd(3'd3, 32'h10, 32'h0, 4'h0, 1, 2'd3, 32'h0, 0);
    do_cmd(3'd7, 32'h0, 32'h0, 4'h0, 1, 2'd3, 32'h0, 2);

    // MRespAccept outside RESP has no effect.
    MRespAccept = 1'b1;
    @(negedge clk);
    MRespAccept = 1'b0;
    chk("stray_rsp", SResp, 0);
    chk("stray_acc", SCmdAccept, 1);

    // Randomized traffic over the first 16 words plus occasional out-of-range reads.
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(15, 0) * 4 + $urandom_range(3, 0));
      d = $urandom;
      case ($urandom_range(3, 0))
        0, 1: do_write(a, d, 4'($urandom_range(15, 0)));
        2:    do_read(a, $urandom_range(2, 0));
        default: do_read(32'h8000_0000 | a, $urandom_range(1, 0));
      endcase
    end

    // Reset during WAIT discards the pending read and keeps RAM contents.
    wait_acc();
    MCmd = 3'd2; MAddr = 32'h10;
    @(negedge clk);
    MCmd = 3'd0;
    chk("wait_state_acc", SCmdAccept, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp", SResp, 0);
    chk("mid_rst_acc", SCmdAccept, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_resp", SResp, 0);
      @(negedge clk);
    end
    chk("post_rst_acc", SCmdAccept, 1);
    do_read(32'h10, 0);
    for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
